int_controller: RTL and testbench



---
 rtl/int_ctrl_pkg.sv | 19 +
 rtl/int_prio_enc.sv | 24 ++
 rtl/int_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_int_controller.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared constants and types for the interrupt sequencer
package int_ctrl_pkg;

    // Register map
    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_PEND  = 2'd1;
    localparam logic [1:0] REG_INSVC = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    // CTRL register: global interrupt enable
    localparam int GIE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } int_state_t;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - lowest-set-bit priority encoder
//
// Ports:
//   vec  in   16  request vector, bit 0 is highest priority
//   idx  out  4   index of the lowest set bit (0 when vec is empty)
//   any  out  1   vec has at least one bit set
module int_prio_enc (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);

    always_comb begin
        idx = 4'd0;
        any = |vec;
        // Walk from the top down so the lowest set bit is written last.
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - IRQ synchroniser, arbiter and pipeline-safe interrupt sequencer
//
// Build option: INT_CTRL_NESTING_EN - when defined, a higher-priority IRQ may
// preempt an active handler; otherwise nothing new arms until reti.
//
// Ports:
//   clk            in   1        CPU clock
//   rst_n          in   1        asynchronous active-low reset
//   irq_in         in   NUM_IRQ  asynchronous IRQ lines, rising-edge sensitive
//   hazard         in   1        pipeline stall
//   branch_hazard  in   1        branch target not yet resolved
//   p_cache_miss   in   1        program-cache miss in progress
//   branch_taken   in   1        jmp/call/taken brx/ret this cycle
//   reti           in   1        return-from-interrupt strobe
//   cfg_we         in   1        register write strobe
//   cfg_addr       in   2        register select (MASK, PEND, INSVC, CTRL)
//   cfg_wdata      in   16       register write data
//   cfg_rdata      out  16       register read data, combinational
//   interrupt      out  1        one-cycle request to the PC
//   int_addr       out  4        vector index to the PC
//   int_active     out  1        any in-service level set
import int_ctrl_pkg::*;

module int_controller #(
    parameter int NUM_IRQ     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               hazard,
    input  logic               branch_hazard,
    input  logic               p_cache_miss,
    input  logic               branch_taken,
    input  logic               reti,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata,
    output logic               interrupt,
    output logic [3:0]         int_addr,
    output logic               int_active
);

    localparam int CNT_W = (HOLDOFF > 2) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] sync_dly_q;
    logic [NUM_IRQ-1:0] edge_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] insvc_q, insvc_d;
    logic               gie_q;
    int_state_t         state_q, state_d;
    logic [3:0]         int_addr_q, int_addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_IRQ-1:0] preempt_ok;
    logic [NUM_IRQ-1:0] cand;
    logic [15:0]        cand16, insvc16, mask16, pend16;
    logic [15:0]        addr_onehot, low_onehot;
    logic [3:0]         winner_idx, low_insvc_idx;
    logic               cand_any, insvc_any;
    logic               safe;

    // Synchroniser chain, then a registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            sync_dly_q <= '0;
            edge_q     <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            sync_dly_q <= sync_q[SYNC_STAGES-1];
            edge_q     <= sync_q[SYNC_STAGES-1] & ~sync_dly_q;
        end
    end

    always_comb begin
        cand16  = '0;
        insvc16 = '0;
        mask16  = '0;
        pend16  = '0;
        cand16[NUM_IRQ-1:0]  = cand;
        insvc16[NUM_IRQ-1:0] = insvc_q;
        mask16[NUM_IRQ-1:0]  = mask_q;
        pend16[NUM_IRQ-1:0]  = pend_q;
    end

    int_prio_enc u_winner_enc (
        .vec (cand16),
        .idx (winner_idx),
        .any (cand_any)
    );

    int_prio_enc u_insvc_enc (
        .vec (insvc16),
        .idx (low_insvc_idx),
        .any (insvc_any)
    );

    // Only levels strictly above the highest active one may be taken.
    always_comb begin
        preempt_ok = '0;
`ifdef INT_CTRL_NESTING_EN
        for (int i = 0; i < NUM_IRQ; i++) begin
            preempt_ok[i] = !insvc_any || (i < int'(low_insvc_idx));
        end
`else
        preempt_ok = insvc_any ? '0 : '1;
`endif
    end

    assign cand        = gie_q ? (pend_q & mask_q & preempt_ok) : '0;
    assign safe        = ~hazard & ~branch_hazard & ~p_cache_miss & ~branch_taken & ~reti;
    assign addr_onehot = 16'd1 << int_addr_q;
    assign low_onehot  = 16'd1 << low_insvc_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        int_addr_d = int_addr_q;
        cnt_d      = cnt_q;
        interrupt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_any) begin
                    state_d    = ARMED;
                    int_addr_d = winner_idx;
                end
            end
            ARMED: begin
                interrupt = safe;
                if (safe) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = HOLD;
                end else if (!cand_any) begin
                    state_d = IDLE;
                end else begin
                    // A higher-priority arrival replaces the armed vector.
                    int_addr_d = winner_idx;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // New edges are applied last so a same-cycle W1C cannot lose them.
    always_comb begin
        pend_d = pend_q;
        if (cfg_we && cfg_addr == REG_PEND) begin
            pend_d = pend_d & ~cfg_wdata[NUM_IRQ-1:0];
        end
        if (interrupt) begin
            pend_d = pend_d & ~addr_onehot[NUM_IRQ-1:0];
        end
        pend_d = pend_d | edge_q;

        insvc_d = insvc_q;
        if (interrupt) begin
            insvc_d = insvc_d | addr_onehot[NUM_IRQ-1:0];
        end
        if (reti && insvc_any) begin
            insvc_d = insvc_d & ~low_onehot[NUM_IRQ-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '0;
            gie_q      <= 1'b0;
            pend_q     <= '0;
            insvc_q    <= '0;
            int_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            if (cfg_we && cfg_addr == REG_MASK) begin
                mask_q <= cfg_wdata[NUM_IRQ-1:0];
            end
            if (cfg_we && cfg_addr == REG_CTRL) begin
                gie_q <= cfg_wdata[GIE_BIT];
            end
            pend_q     <= pend_d;
            insvc_q    <= insvc_d;
            int_addr_q <= int_addr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            REG_MASK:  cfg_rdata = mask16;
            REG_PEND:  cfg_rdata = pend16;
            REG_INSVC: cfg_rdata = insvc16;
            REG_CTRL:  cfg_rdata[GIE_BIT] = gie_q;
            default:   cfg_rdata = '0;
        endcase
    end

    assign int_addr   = int_addr_q;
    assign int_active = |insvc_q;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - self-checking bench for int_controller
module tb_int_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] irq_in;
    logic        hazard, branch_hazard, p_cache_miss, branch_taken, reti;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        interrupt;
    logic [3:0]  int_addr;
    logic        int_active;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  exp_q [$];
    logic        prev_int = 1'b0;

    int_controller #(.NUM_IRQ(16), .SYNC_STAGES(2), .HOLDOFF(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_in        (irq_in),
        .hazard        (hazard),
        .branch_hazard (branch_hazard),
        .p_cache_miss  (p_cache_miss),
        .branch_taken  (branch_taken),
        .reti          (reti),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_rdata     (cfg_rdata),
        .interrupt     (interrupt),
        .int_addr      (int_addr),
        .int_active    (int_active)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every interrupt pulse must match the next queued vector.
    always @(negedge clk) begin
        logic [3:0] exp_addr;
        #2;
        if (rst_n) begin
            if (interrupt) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: interrupt=1 int_addr=%0d, required no interrupt", int_addr);
                end else begin
                    exp_addr = exp_q.pop_front();
                    if (int_addr !== exp_addr) begin
                        n_fail++;
                        $display("FAIL sb_addr: int_addr=%0d, required %0d", int_addr, exp_addr);
                    end
                end
                n_checks++;
                if (prev_int) begin
                    n_fail++;
                    $display("FAIL sb_consecutive: interrupt high two cycles, required one");
                end
            end
            prev_int = interrupt;
        end else begin
            prev_int = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
        cfg_wdata = 16'h0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic pulse_reti;
        reti = 1'b1;
        @(negedge clk);
        reti = 1'b0;
    endtask

    task automatic wait_int(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #1;
            if (interrupt) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [15:0] d;
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            n_checks++;
            if (d !== 16'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: read %h, required 0000", a, d);
            end
        end
        n_checks++;
        if (interrupt !== 1'b0 || int_addr !== 4'd0 || int_active !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: interrupt=%b int_addr=%0d int_active=%b, required 0 0 0",
                     interrupt, int_addr, int_active);
        end
    endtask

    task automatic test_basic;
        logic [15:0] d;
        write_reg(int_ctrl_pkg::REG_MASK, 16'h0001);
        write_reg(int_ctrl_pkg::REG_CTRL, 16'h0001);
        exp_q.push_back(4'd0);
        irq_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (interrupt !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early_edge%0d: interrupt=%b, required 0", k, interrupt);
            end
        end
        read_reg(int_ctrl_pkg::REG_PEND, d);
        n_checks++;
        if (d !== 16'h0001) begin
            n_fail++;
            $display("FAIL basic_pend_set: PEND=%h, required 0001", d);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (interrupt !== 1'b1 || int_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL basic_fire: interrupt=%b int_addr=%0d, required 1 0", interrupt, int_addr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: interrupt=%b, required 0", interrupt);
        end
        read_reg(int_ctrl_pkg::REG_PEND, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++;
            $display("FAIL basic_pend_clr: PEND=%h, required 0000", d);
        end
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0001 || int_active !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_insvc: INSVC=%h int_active=%b, required 0001 1", d, int_active);
        end
        irq_in[0] = 1'b0;
        @(negedge clk);
        pulse_reti();
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0000 || int_active !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_reti: INSVC=%h int_active=%b, required 0000 0", d, int_active);
        end
        cyc(4);
    endtask

    task automatic test_gates;
        logic [4:0] gates;
        write_reg(int_ctrl_pkg::REG_MASK, 16'hFFFF);
        hazard = 1'b1;
        exp_q.push_back(4'd5);
        irq_in[5] = 1'b1;
        cyc(6);
        // One blocking condition at a time, rotating through all five.
        for (int k = 0; k < 10; k++) begin
            gates = 5'b10000 >> (k % 5);
            {hazard, branch_hazard, p_cache_miss, branch_taken, reti} = gates;
            #1;
            n_checks++;
            if (interrupt !== 1'b0 || int_addr !== 4'd5) begin
                n_fail++;
                $display("FAIL gates_block%0d: interrupt=%b int_addr=%0d, required 0 5", k, interrupt, int_addr);
            end
            @(negedge clk);
        end
        {hazard, branch_hazard, p_cache_miss, branch_taken, reti} = 5'b0;
        #1;
        n_checks++;
        if (interrupt !== 1'b1 || int_addr !== 4'd5) begin
            n_fail++;
            $display("FAIL gates_release: interrupt=%b int_addr=%0d, required 1 5", interrupt, int_addr);
        end
        irq_in[5] = 1'b0;
        @(negedge clk);
        pulse_reti();
        cyc(4);
    endtask

    task automatic test_replace;
        logic [15:0] d;
        bit          seen;
        hazard = 1'b1;
        irq_in[7] = 1'b1;
        cyc(6);
        #1;
        n_checks++;
        if (int_addr !== 4'd7) begin
            n_fail++;
            $display("FAIL replace_armed7: int_addr=%0d, required 7", int_addr);
        end
        irq_in[2] = 1'b1;
        cyc(6);
        #1;
        n_checks++;
        if (int_addr !== 4'd2 || interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL replace_to2: int_addr=%0d interrupt=%b, required 2 0", int_addr, interrupt);
        end
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd7);
        @(negedge clk);
        hazard = 1'b0;
        #1;
        n_checks++;
        if (interrupt !== 1'b1 || int_addr !== 4'd2) begin
            n_fail++;
            $display("FAIL replace_fire2: interrupt=%b int_addr=%0d, required 1 2", interrupt, int_addr);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (interrupt !== 1'b0) begin
                n_fail++;
                $display("FAIL replace_blocked%0d: interrupt=%b, required 0", k, interrupt);
            end
        end
        read_reg(int_ctrl_pkg::REG_PEND, d);
        n_checks++;
        if (d !== 16'h0080) begin
            n_fail++;
            $display("FAIL replace_pend: PEND=%h, required 0080", d);
        end
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0004) begin
            n_fail++;
            $display("FAIL replace_insvc: INSVC=%h, required 0004", d);
        end
        irq_in[2] = 1'b0;
        irq_in[7] = 1'b0;
        @(negedge clk);
        pulse_reti();
        wait_int(10, seen);
        n_checks++;
        if (!seen || int_addr !== 4'd7) begin
            n_fail++;
            $display("FAIL replace_fire7: seen=%b int_addr=%0d, required 1 7", seen, int_addr);
        end
        @(negedge clk);
        pulse_reti();
        cyc(4);
    endtask

    task automatic test_nesting;
        logic [15:0] d;
        bit          seen;
        exp_q.push_back(4'd4);
        irq_in[4] = 1'b1;
        wait_int(10, seen);
        n_checks++;
        if (!seen || int_addr !== 4'd4) begin
            n_fail++;
            $display("FAIL nest_fire4: seen=%b int_addr=%0d, required 1 4", seen, int_addr);
        end
        irq_in[4] = 1'b0;
        cyc(5);
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0010) begin
            n_fail++;
            $display("FAIL nest_insvc4: INSVC=%h, required 0010", d);
        end
        @(negedge clk);
        irq_in[1] = 1'b1;
`ifdef INT_CTRL_NESTING_EN
        exp_q.push_back(4'd1);
        wait_int(12, seen);
        n_checks++;
        if (!seen || int_addr !== 4'd1) begin
            n_fail++;
            $display("FAIL nest_preempt: seen=%b int_addr=%0d, required 1 1", seen, int_addr);
        end
        cyc(4);
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0012) begin
            n_fail++;
            $display("FAIL nest_insvc_both: INSVC=%h, required 0012", d);
        end
        @(negedge clk);
        pulse_reti();
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0010) begin
            n_fail++;
            $display("FAIL nest_reti_lowest: INSVC=%h, required 0010", d);
        end
        @(negedge clk);
        pulse_reti();
`else
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (interrupt !== 1'b0) begin
                n_fail++;
                $display("FAIL nest_blocked%0d: interrupt=%b, required 0", k, interrupt);
            end
        end
        read_reg(int_ctrl_pkg::REG_PEND, d);
        n_checks++;
        if (d !== 16'h0002) begin
            n_fail++;
            $display("FAIL nest_pend1: PEND=%h, required 0002", d);
        end
        exp_q.push_back(4'd1);
        @(negedge clk);
        pulse_reti();
        wait_int(10, seen);
        n_checks++;
        if (!seen || int_addr !== 4'd1) begin
            n_fail++;
            $display("FAIL nest_after_reti: seen=%b int_addr=%0d, required 1 1", seen, int_addr);
        end
        cyc(4);
        read_reg(int_ctrl_pkg::REG_INSVC, d);
        n_checks++;
        if (d !== 16'h0002) begin
            n_fail++;
            $display("FAIL nest_insvc1: INSVC=%h, required 0002", d);
        end
        @(negedge clk);
        pulse_reti();
`endif
        irq_in[1] = 1'b0;
        cyc(4);
    endtask

    task automatic test_w1c_collision;
        logic [15:0] d;
        write_reg(int_ctrl_pkg::REG_CTRL, 16'h0000);
        irq_in[3] = 1'b1;
        cyc(3);
        // W1C lands on the same edge that latches the detected rise.
        cfg_we    = 1'b1;
        cfg_addr  = int_ctrl_pkg::REG_PEND;
        cfg_wdata = 16'h0008;
        @(negedge clk);
        cfg_we    = 1'b0;
        cfg_wdata = 16'h0;
        read_reg(int_ctrl_pkg::REG_PEND, d);
        n_checks++;
        if (d !== 16'h0008) begin
            n_fail++;
            $display("FAIL w1c_set_wins: PEND=%h, required 0008", d);
        end
        @(negedge clk);
        write_reg(int_ctrl_pkg::REG_PEND, 16'h0008);
        read_reg(int_ctrl_pkg::REG_PEND, d);
        n_checks++;
        if (d !== 16'h0000) begin
            n_fail++;
            $display("FAIL w1c_clear: PEND=%h, required 0000", d);
        end
        irq_in[3] = 1'b0;
        cyc(2);
    endtask

    task automatic test_reset_armed;
        logic [15:0] d;
        write_reg(int_ctrl_pkg::REG_MASK, 16'hFFFF);
        write_reg(int_ctrl_pkg::REG_CTRL, 16'h0001);
        irq_in[6] = 1'b1;
        cyc(5);
        #1;
        n_checks++;
        if (interrupt !== 1'b1 || int_addr !== 4'd6) begin
            n_fail++;
            $display("FAIL rst_armed_fire: interrupt=%b int_addr=%0d, required 1 6", interrupt, int_addr);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (interrupt !== 1'b0 || int_addr !== 4'd0 || int_active !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: interrupt=%b int_addr=%0d int_active=%b, required 0 0 0",
                     interrupt, int_addr, int_active);
        end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), d);
            n_checks++;
            if (d !== 16'h0) begin
                n_fail++;
                $display("FAIL rst_reg%0d: read %h, required 0000", a, d);
            end
        end
        irq_in[6] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        write_reg(int_ctrl_pkg::REG_MASK, 16'hFFFF);
        write_reg(int_ctrl_pkg::REG_CTRL, 16'h0001);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (interrupt !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_refire%0d: interrupt=%b, required 0", k, interrupt);
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        irq_in        = 16'h0;
        hazard        = 1'b0;
        branch_hazard = 1'b0;
        p_cache_miss  = 1'b0;
        branch_taken  = 1'b0;
        reti          = 1'b0;
        cfg_we        = 1'b0;
        cfg_addr      = 2'd0;
        cfg_wdata     = 16'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        test_reset();
        test_basic();
        test_gates();
        test_replace();
        test_nesting();
        test_w1c_collision();
        test_reset_armed();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d expected interrupts never seen, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
